// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size codes, state encoding and alignment check
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   // Reserved size code counts as misaligned so it never reaches memory.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// rtl/mem_access_unit_lane_align.sv - little-endian byte-lane merge and load extraction
module lane_align
   import mem_pkg::*;
(
   input  logic [31:0] old_word_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rd_word_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        sign_ext_i,
   output logic [31:0] merged_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Store merge: replace only the addressed lanes of the previously read word.
   always_comb begin
      merged_o = old_word_i;
      case (size_i)
         SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8]        = wdata_i[7:0];
         SZ_HALF: merged_o[{addr_lo_i[1], 4'b0000} +: 16]   = wdata_i[15:0];
         default: merged_o = wdata_i;
      endcase
   end

   // Load extract: pick the addressed lanes and extend; word loads pass through.
   always_comb begin
      byte_v = rd_word_i[{addr_lo_i, 3'b000} +: 8];
      half_v = rd_word_i[{addr_lo_i[1], 4'b0000} +: 16];
      case (size_i)
         SZ_BYTE: rdata_o = {{24{sign_ext_i & byte_v[7]}}, byte_v};
         SZ_HALF: rdata_o = {{16{sign_ext_i & half_v[15]}}, half_v};
         default: rdata_o = rd_word_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer converting sub-word accesses to word cycles
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              req,
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ack,
   output logic              misalign,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_dout
);

   state_t            state_q, state_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic              sext_q, sext_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [31:0]       merged;
   logic [31:0]       load_val;

   lane_align u_lane_align (
      .old_word_i (word_q),
      .wdata_i    (wdata_q),
      .rd_word_i  (mem_dout),
      .size_i     (size_q),
      .addr_lo_i  (addr_q[1:0]),
      .sign_ext_i (sext_q),
      .merged_o   (merged),
      .rdata_o    (load_val)
   );

   // State and latched request fields; async clear drops mem_we immediately.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         sext_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         word_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state sequencing: accept in IDLE, read for loads/sub-word stores, write, then ack.
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      size_d  = size_q;
      sext_d  = sext_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      word_d  = word_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               wr_d    = wr;
               size_d  = size;
               sext_d  = sign_ext;
               addr_d  = addr;
               wdata_d = wdata;
               err_d   = is_misaligned(size, addr[1:0]);
               if (is_misaligned(size, addr[1:0]))
                  state_d = DONE;
               else if (wr && (size == SZ_WORD))
                  state_d = WR;
               else
                  state_d = RD;
            end
         end
         RD: begin
            word_d = mem_dout;
            if (wr_q) begin
               state_d = WR;
            end else begin
               rdata_d = load_val;
               state_d = DONE;
            end
         end
         WR:      state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded purely from registered state and latched fields.
   always_comb begin
      ack      = (state_q == DONE);
      misalign = (state_q == DONE) && err_q;
      busy     = (state_q != IDLE);
      mem_we   = (state_q == WR);
      mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
      mem_din  = (size_q == SZ_WORD) ? wdata_q : merged;
      rdata    = rdata_q;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench with byte-array reference model
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        sign_ext = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        ack, misalign, busy, mem_we;
   logic [31:0] rdata, mem_addr, mem_din, mem_dout;

   logic [31:0] mem [0:31];
   logic [7:0]  ref_b [0:127];
   logic [31:0] ref_rdata = '0;

   int total = 0;
   int bad = 0;
   int we_cnt = 0;
   logic ack_prev = 1'b0;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .clrn(clrn), .req(req), .wr(wr), .size(size), .sign_ext(sign_ext),
      .addr(addr), .wdata(wdata), .ack(ack), .misalign(misalign), .rdata(rdata),
      .busy(busy), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   assign mem_dout = mem[mem_addr[6:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[6:2]] <= mem_din;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we) we_cnt++;
      if (ack_prev) chk("ack_single", {31'b0, ack}, 32'd0);
      ack_prev = ack;
   end

   function automatic logic ref_mis(input logic [1:0] s, input logic [31:0] a);
      if (s == 2'd3) return 1'b1;
      if (s == 2'd1) return (a % 2) != 0;
      if (s == 2'd2) return (a % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      int b;
      b = int'(a[6:0]) & ~3;
      return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] s, input logic se, input logic [31:0] a);
      int b;
      logic [15:0] h;
      b = int'(a[6:0]);
      if (s == 2'd0) return (se && ref_b[b][7]) ? {24'hFFFFFF, ref_b[b]} : {24'h0, ref_b[b]};
      if (s == 2'd1) begin
         h = {ref_b[b+1], ref_b[b]};
         return (se && h[15]) ? {16'hFFFF, h} : {16'h0, h};
      end
      return ref_word(a);
   endfunction

   task automatic ref_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      int b, n;
      b = int'(a[6:0]);
      n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      for (int i = 0; i < n; i++) ref_b[b+i] = d[8*i +: 8];
   endtask

   task automatic do_access(input logic w, input logic [1:0] s, input logic se,
                            input logic [31:0] a, input logic [31:0] d, input string tag);
      logic mis;
      int exp_lat, exp_we, lat;
      mis     = ref_mis(s, a);
      exp_lat = mis ? 1 : (w && s != 2'd2) ? 3 : 2;
      exp_we  = (!mis && w) ? 1 : 0;
      @(negedge clk);
      req = 1'b1; wr = w; size = s; sign_ext = se; addr = a; wdata = d;
      we_cnt = 0;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0; wr = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
      lat = 1;
      while (!ack && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_misalign"}, {31'b0, misalign}, {31'b0, mis});
      chk({tag, "_busy_at_ack"}, {31'b0, busy}, 32'd1);
      chk({tag, "_we_count"}, we_cnt, exp_we);
      if (!mis && !w) ref_rdata = ref_load(s, se, a);
      chk({tag, "_rdata"}, rdata, ref_rdata);
      if (!mis && w) ref_store(s, a, d);
      chk({tag, "_memword"}, mem[a[6:2]], ref_word(a));
      @(negedge clk);
      chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] w32, ra;
      logic [1:0]  rs;
      for (int i = 0; i < 32; i++) begin
         w32 = $urandom;
         if (i == 32'h4C / 4) w32 = 32'h7FFFFFFF;
         if (i == 32'h50 / 4) w32 = 32'h000000A3;
         mem[i] = w32;
         for (int k = 0; k < 4; k++) ref_b[4*i+k] = w32[8*k +: 8];
      end

      repeat (3) @(negedge clk);
      chk("reset_ack", {31'b0, ack}, 32'd0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_we", {31'b0, mem_we}, 32'd0);
      chk("reset_misalign", {31'b0, misalign}, 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_mem_addr", mem_addr, 32'd0);
      chk("reset_mem_din", mem_din, 32'd0);
      clrn = 1'b1;

      do_access(1'b0, 2'd2, 1'b0, 32'h4C, 32'h0, "ld_word_4c");
      chk("ld_word_4c_const", rdata, 32'h7FFFFFFF);
      do_access(1'b0, 2'd0, 1'b1, 32'h50, 32'h0, "ld_byte_sx");
      chk("ld_byte_sx_const", rdata, 32'hFFFFFFA3);
      do_access(1'b0, 2'd0, 1'b0, 32'h50, 32'h0, "ld_byte_zx");
      chk("ld_byte_zx_const", rdata, 32'h000000A3);
      do_access(1'b1, 2'd0, 1'b0, 32'h4D, 32'h55, "st_byte_4d");
      chk("st_byte_4d_const", mem[32'h4C / 4], 32'h7FFF55FF);
      do_access(1'b1, 2'd2, 1'b0, 32'h60, 32'h258, "st_word_60");
      do_access(1'b0, 2'd1, 1'b1, 32'h60, 32'h0, "ld_half_60");
      chk("ld_half_60_const", rdata, 32'h00000258);
      do_access(1'b0, 2'd1, 1'b1, 32'h62, 32'h0, "ld_half_62");
      chk("ld_half_62_const", rdata, 32'h00000000);
      do_access(1'b0, 2'd2, 1'b0, 32'h4A, 32'h0, "mis_ld_word");
      do_access(1'b1, 2'd1, 1'b0, 32'h4F, 32'h1234, "mis_st_half");
      do_access(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, "mis_size3");

      // Reset pulsed during RD of a sub-word store.
      @(negedge clk);
      req = 1'b1; wr = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h4C; wdata = 32'hAA;
      we_cnt = 0;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      chk("rst_mid_in_rd", {31'b0, busy}, 32'd1);
      #1 clrn = 1'b0;
      #1;
      chk("rst_mid_ack", {31'b0, ack}, 32'd0);
      chk("rst_mid_busy", {31'b0, busy}, 32'd0);
      chk("rst_mid_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mid_rdata", rdata, 32'd0);
      chk("rst_mid_mem_addr", mem_addr, 32'd0);
      chk("rst_mid_mem_din", mem_din, 32'd0);
      ref_rdata = '0;
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      chk("rst_mid_no_we", we_cnt, 32'd0);
      chk("rst_mid_word_kept", mem[32'h4C / 4], ref_word(32'h4C));
      do_access(1'b0, 2'd2, 1'b0, 32'h4C, 32'h0, "after_rst_ld");

      for (int n = 0; n < 40; n++) begin
         rs = 2'($urandom_range(0, 3));
         ra = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (rs == 2'd1) ra[0] = 1'b0;
            if (rs == 2'd2) ra[1:0] = 2'b00;
         end
         do_access(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $error("FAIL timeout observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
